// File: rtl/interp_mode_ctrl.sv
// ---------------------------------------------------------------------------
// interp_mode_ctrl
//
// Frame-synchronous configuration owner for the demosaic stage. Requests for
// interpolation mode and Bayer phase arrive asynchronously to the video
// timing. They are only applied while no frame is in flight, so a frame is
// never processed with two different configurations. The in-flight frame is
// tracked from its FRAME_START on the raw input stream until its FRAME_END
// leaves the interpolator output mux. A drain timeout guards against a lost
// output FRAME_END.
//
// Ports:
//   img_clk          in   pixel clock, the only clock
//   resetb           in   asynchronous active-low reset
//   req_mode[1:0]    in   0 bypass, 1 bilinear, 2 edge-directed, 3 = 1
//   req_phase[1:0]   in   requested Bayer phase
//   err_clr          in   pulse, clears the sticky error bits
//   dvi / dtypei     in   raw input stream valid / dtype
//   dvo_mux /
//   dtypeo_mux       in   muxed interpolator output valid / dtype
//   enable_bilinear  out  bilinear interpolator enable
//   enable_ed        out  edge-directed enable, also output mux select
//   phase[1:0]       out  applied Bayer phase
//   busy             out  state != IDLE
//   state[1:0]       out  0 IDLE, 1 RUN, 2 DRAIN
//   timeout_err      out  sticky, drain timed out
//   sync_err         out  sticky, FRAME_START seen while in RUN
//   frame_count[15:0]  out  accepted frame starts (wraps)
//   switch_count[7:0]  out  applied configuration changes (wraps)
// ---------------------------------------------------------------------------
module interp_mode_ctrl #(
   parameter int                     DTYPE_WIDTH    = 5,
   parameter logic [DTYPE_WIDTH-1:0] FRAME_START    = 5'h01,
   parameter logic [DTYPE_WIDTH-1:0] FRAME_END      = 5'h02,
   parameter int                     TIMEOUT_CYCLES = 4096,
   parameter int                     CNT_WIDTH      = 13
) (
   input  logic                   img_clk,
   input  logic                   resetb,
   input  logic [1:0]             req_mode,
   input  logic [1:0]             req_phase,
   input  logic                   err_clr,
   input  logic                   dvi,
   input  logic [DTYPE_WIDTH-1:0] dtypei,
   input  logic                   dvo_mux,
   input  logic [DTYPE_WIDTH-1:0] dtypeo_mux,
   output logic                   enable_bilinear,
   output logic                   enable_ed,
   output logic [1:0]             phase,
   output logic                   busy,
   output logic [1:0]             state,
   output logic                   timeout_err,
   output logic                   sync_err,
   output logic [15:0]            frame_count,
   output logic [7:0]             switch_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [1:0]           MODE_BYPASS = 2'd0;
   localparam logic [1:0]           MODE_BIL    = 2'd1;
   localparam logic [1:0]           MODE_ED     = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               r_state,  w_state_next;
   logic [1:0]           r_mode,   w_mode_next;
   logic [1:0]           r_phase,  w_phase_next;
   logic                 r_en_bl,  r_en_ed;
   logic [CNT_WIDTH-1:0] r_cnt,    w_cnt_next;
   logic                 r_tmo_err, w_tmo_err_next;
   logic                 r_sync_err, w_sync_err_next;
   logic [15:0]          r_frame_cnt, w_frame_cnt_next;
   logic [7:0]           r_switch_cnt, w_switch_cnt_next;

   logic       w_in_fs, w_in_fe, w_out_fe;
   logic [1:0] w_req_mode_n;
   logic       w_load_cfg, w_set_tmo, w_set_sync, w_frame_inc;

   assign w_in_fs  = dvi     && (dtypei     == FRAME_START);
   assign w_in_fe  = dvi     && (dtypei     == FRAME_END);
   assign w_out_fe = dvo_mux && (dtypeo_mux == FRAME_END);

   // Mode 3 is an alias of bilinear; normalise before storing so that a
   // 3 <-> 1 request change is not counted as a configuration switch.
   assign w_req_mode_n = (req_mode == 2'd3) ? MODE_BIL : req_mode;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_load_cfg   = 1'b0;
      w_set_tmo    = 1'b0;
      w_set_sync   = 1'b0;
      w_frame_inc  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // The frame-start word is processed with the configuration that
            // is already registered, so no load on that cycle.
            if (w_in_fs) begin
               w_state_next = ST_RUN;
               w_frame_inc  = 1'b1;
            end else begin
               w_load_cfg = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_in_fe) begin
               w_state_next = ST_DRAIN;
               w_cnt_next   = '0;
            end else if (w_in_fs) begin
               w_set_sync  = 1'b1;
               w_frame_inc = 1'b1;
            end
         end
         ST_DRAIN: begin
            w_cnt_next = r_cnt + 1'b1;
            if (w_in_fs) begin
               // Next frame overtakes the drain: configuration stays frozen.
               w_state_next = ST_RUN;
               w_frame_inc  = 1'b1;
            end else if (w_out_fe) begin
               w_state_next = ST_IDLE;
            end else if (r_mode == MODE_BYPASS) begin
               // Bypass has no interpolator pipeline to empty.
               w_state_next = ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_set_tmo    = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      w_mode_next       = w_load_cfg ? w_req_mode_n : r_mode;
      w_phase_next      = w_load_cfg ? req_phase    : r_phase;
      w_switch_cnt_next = r_switch_cnt;
      if (w_load_cfg && ({w_req_mode_n, req_phase} != {r_mode, r_phase}))
         w_switch_cnt_next = r_switch_cnt + 8'd1;
      w_frame_cnt_next  = w_frame_inc ? (r_frame_cnt + 16'd1) : r_frame_cnt;

      // A new error event in the same cycle as err_clr leaves the bit set.
      w_tmo_err_next  = w_set_tmo  ? 1'b1 : (err_clr ? 1'b0 : r_tmo_err);
      w_sync_err_next = w_set_sync ? 1'b1 : (err_clr ? 1'b0 : r_sync_err);
   end

   always_ff @(posedge img_clk or negedge resetb) begin
      if (!resetb) begin
         r_state      <= ST_IDLE;
         r_mode       <= MODE_BYPASS;
         r_phase      <= 2'd0;
         r_en_bl      <= 1'b0;
         r_en_ed      <= 1'b0;
         r_cnt        <= '0;
         r_tmo_err    <= 1'b0;
         r_sync_err   <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_switch_cnt <= 8'd0;
      end else begin
         r_state      <= w_state_next;
         r_mode       <= w_mode_next;
         r_phase      <= w_phase_next;
         // Enables are decoded from the next mode so they update in the same
         // clock as the stored configuration; at most one can be set.
         r_en_bl      <= (w_mode_next == MODE_BIL);
         r_en_ed      <= (w_mode_next == MODE_ED);
         r_cnt        <= w_cnt_next;
         r_tmo_err    <= w_tmo_err_next;
         r_sync_err   <= w_sync_err_next;
         r_frame_cnt  <= w_frame_cnt_next;
         r_switch_cnt <= w_switch_cnt_next;
      end
   end

   assign enable_bilinear = r_en_bl;
   assign enable_ed       = r_en_ed;
   assign phase           = r_phase;
   assign state           = r_state;
   assign busy            = (r_state != ST_IDLE);
   assign timeout_err     = r_tmo_err;
   assign sync_err        = r_sync_err;
   assign frame_count     = r_frame_cnt;
   assign switch_count    = r_switch_cnt;

endmodule

// File: tb/tb_interp_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interp_mode_ctrl
//
// Directed testbench for interp_mode_ctrl. Inputs are driven and outputs
// sampled 1 ns after the rising clock edge. A second instance with
// FRAME_START == FRAME_END makes in_fs and in_fe coincide, which is not
// possible with distinct dtype codes on a single stream.
// ---------------------------------------------------------------------------
module tb_interp_mode_ctrl;

   localparam logic [4:0] FS = 5'h01;
   localparam logic [4:0] FE = 5'h02;
   localparam logic [4:0] FX = 5'h03;

   logic       img_clk;
   logic       resetb;
   logic [1:0] req_mode;
   logic [1:0] req_phase;
   logic       err_clr;
   logic       dvi;
   logic [4:0] dtypei;
   logic       dvo_mux;
   logic [4:0] dtypeo_mux;

   logic        enable_bilinear, enable_ed, busy, timeout_err, sync_err;
   logic [1:0]  phase, state;
   logic [15:0] frame_count;
   logic [7:0]  switch_count;

   logic        e_en_bl, e_en_ed, e_busy, e_tmo, e_sync;
   logic [1:0]  e_phase, e_state;
   logic [15:0] e_frame;
   logic [7:0]  e_switch;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_frame = 16'd0;
   logic [7:0]  exp_switch = 8'd0;

   interp_mode_ctrl u_dut (
      .img_clk(img_clk), .resetb(resetb), .req_mode(req_mode), .req_phase(req_phase),
      .err_clr(err_clr), .dvi(dvi), .dtypei(dtypei), .dvo_mux(dvo_mux),
      .dtypeo_mux(dtypeo_mux), .enable_bilinear(enable_bilinear), .enable_ed(enable_ed),
      .phase(phase), .busy(busy), .state(state), .timeout_err(timeout_err),
      .sync_err(sync_err), .frame_count(frame_count), .switch_count(switch_count)
   );

   interp_mode_ctrl #(.FRAME_START(FX), .FRAME_END(FX)) u_dut_eq (
      .img_clk(img_clk), .resetb(resetb), .req_mode(req_mode), .req_phase(req_phase),
      .err_clr(err_clr), .dvi(dvi), .dtypei(dtypei), .dvo_mux(dvo_mux),
      .dtypeo_mux(dtypeo_mux), .enable_bilinear(e_en_bl), .enable_ed(e_en_ed),
      .phase(e_phase), .busy(e_busy), .state(e_state), .timeout_err(e_tmo),
      .sync_err(e_sync), .frame_count(e_frame), .switch_count(e_switch)
   );

   initial begin
      img_clk = 1'b0;
      forever #5 img_clk = ~img_clk;
   end

   task automatic tick();
      @(posedge img_clk);
      #1;
   endtask

   // One-cycle word on the raw input stream.
   task automatic send_in(input logic [4:0] dt);
      dvi = 1'b1;
      dtypei = dt;
      tick();
      dvi = 1'b0;
      dtypei = 5'h00;
   endtask

   task automatic test_reset();
      resetb = 1'b0; req_mode = 2'd0; req_phase = 2'd0; err_clr = 1'b0;
      dvi = 1'b0; dtypei = 5'h00; dvo_mux = 1'b0; dtypeo_mux = 5'h00;
      tick(); tick();
      checks++;
      if ({enable_bilinear, enable_ed, phase, busy, state, timeout_err, sync_err} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {enable_bilinear, enable_ed, phase, busy, state, timeout_err, sync_err});
      end
      checks++;
      if (frame_count !== 16'd0 || switch_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_counts: got frame=%0d switch=%0d expected 0 0", frame_count, switch_count);
      end
      resetb = 1'b1;
      tick();
      checks++;
      if (state !== 2'd0 || switch_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_release: got state=%0d switch=%0d expected 0 0", state, switch_count);
      end
      $display("test_reset: state=%0d frame=%0d switch=%0d", state, frame_count, switch_count);
   endtask

   task automatic test_simultaneous();
      send_in(FX);
      checks++;
      if (e_state !== 2'd1 || state !== 2'd0) begin
         errors++;
         $display("FAIL simul_start: got eq_state=%0d main_state=%0d expected 1 0", e_state, state);
      end
      send_in(FX);
      checks++;
      if (e_state !== 2'd2 || e_sync !== 1'b0) begin
         errors++;
         $display("FAIL simul_fe_priority: got state=%0d sync_err=%0d expected 2 0", e_state, e_sync);
      end
      tick(); tick();
      $display("test_simultaneous: eq_state=%0d eq_frame=%0d", e_state, e_frame);
   endtask

   task automatic test_idle_follow();
      req_mode = 2'd2; req_phase = 2'd1;
      tick(); tick();
      exp_switch = exp_switch + 8'd1;
      checks++;
      if (enable_ed !== 1'b1 || enable_bilinear !== 1'b0 || phase !== 2'd1) begin
         errors++;
         $display("FAIL idle_follow_cfg: got ed=%0d bl=%0d phase=%0d expected 1 0 1",
                  enable_ed, enable_bilinear, phase);
      end
      checks++;
      if (switch_count !== exp_switch || state !== 2'd0) begin
         errors++;
         $display("FAIL idle_follow_cnt: got switch=%0d state=%0d expected %0d 0",
                  switch_count, state, exp_switch);
      end
      $display("test_idle_follow: ed=%0d phase=%0d switch=%0d", enable_ed, phase, switch_count);
   endtask

   task automatic test_frame_drain();
      send_in(FS);
      exp_frame = exp_frame + 16'd1;
      checks++;
      if (state !== 2'd1 || frame_count !== exp_frame || busy !== 1'b1) begin
         errors++;
         $display("FAIL frame_start: got state=%0d frame=%0d busy=%0d expected 1 %0d 1",
                  state, frame_count, busy, exp_frame);
      end
      req_mode = 2'd1;
      tick(); tick(); tick();
      checks++;
      if (enable_ed !== 1'b1 || enable_bilinear !== 1'b0) begin
         errors++;
         $display("FAIL frozen_run: got ed=%0d bl=%0d expected 1 0", enable_ed, enable_bilinear);
      end
      send_in(FE);
      // 20 DRAIN clocks; out_fe accompanies the last one.
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (state !== 2'd2) begin
            errors++;
            $display("FAIL drain_hold: cycle %0d got state=%0d expected 2", i, state);
         end
         if (i == 19) begin
            dvo_mux = 1'b1;
            dtypeo_mux = FE;
         end
         tick();
      end
      dvo_mux = 1'b0; dtypeo_mux = 5'h00;
      checks++;
      if (state !== 2'd0 || enable_bilinear !== 1'b0 || enable_ed !== 1'b1) begin
         errors++;
         $display("FAIL drain_exit: got state=%0d bl=%0d ed=%0d expected 0 0 1",
                  state, enable_bilinear, enable_ed);
      end
      tick();
      exp_switch = exp_switch + 8'd1;
      checks++;
      if (enable_bilinear !== 1'b1 || enable_ed !== 1'b0 || switch_count !== exp_switch) begin
         errors++;
         $display("FAIL idle_apply: got bl=%0d ed=%0d switch=%0d expected 1 0 %0d",
                  enable_bilinear, enable_ed, switch_count, exp_switch);
      end
      $display("test_frame_drain: state=%0d bl=%0d switch=%0d", state, enable_bilinear, switch_count);
   endtask

   task automatic test_bypass_drain();
      req_mode = 2'd0;
      tick();
      exp_switch = exp_switch + 8'd1;
      send_in(FS);
      exp_frame = exp_frame + 16'd1;
      tick();
      send_in(FE);
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("FAIL bypass_enter: got state=%0d expected 2", state);
      end
      tick();
      checks++;
      if (state !== 2'd0 || timeout_err !== 1'b0 || enable_bilinear !== 1'b0 || enable_ed !== 1'b0) begin
         errors++;
         $display("FAIL bypass_drain: got state=%0d tmo=%0d bl=%0d ed=%0d expected 0 0 0 0",
                  state, timeout_err, enable_bilinear, enable_ed);
      end
      $display("test_bypass_drain: state=%0d frame=%0d", state, frame_count);
   endtask

   task automatic test_timeout();
      req_mode = 2'd1;
      tick();
      exp_switch = exp_switch + 8'd1;
      send_in(FS);
      exp_frame = exp_frame + 16'd1;
      send_in(FE);
      repeat (4095) tick();
      checks++;
      if (state !== 2'd2 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_edge: got state=%0d tmo=%0d expected 2 0", state, timeout_err);
      end
      tick();
      checks++;
      if (state !== 2'd0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_fire: got state=%0d tmo=%0d expected 0 1", state, timeout_err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clr: got tmo=%0d expected 0", timeout_err);
      end
      $display("test_timeout: state=%0d tmo=%0d", state, timeout_err);
   endtask

   task automatic test_sync_err();
      send_in(FS);
      exp_frame = exp_frame + 16'd1;
      tick();
      send_in(FS);
      exp_frame = exp_frame + 16'd1;
      checks++;
      if (sync_err !== 1'b1 || frame_count !== exp_frame || state !== 2'd1) begin
         errors++;
         $display("FAIL sync_err: got sync=%0d frame=%0d state=%0d expected 1 %0d 1",
                  sync_err, frame_count, state, exp_frame);
      end
      // Clear coinciding with a fresh error: the error wins.
      err_clr = 1'b1;
      send_in(FS);
      err_clr = 1'b0;
      exp_frame = exp_frame + 16'd1;
      checks++;
      if (sync_err !== 1'b1 || frame_count !== exp_frame) begin
         errors++;
         $display("FAIL sync_clr_race: got sync=%0d frame=%0d expected 1 %0d",
                  sync_err, frame_count, exp_frame);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (sync_err !== 1'b0 || state !== 2'd1) begin
         errors++;
         $display("FAIL sync_clr: got sync=%0d state=%0d expected 0 1", sync_err, state);
      end
      $display("test_sync_err: frame=%0d sync=%0d", frame_count, sync_err);
   endtask

   task automatic test_drain_refs();
      send_in(FE);
      req_mode = 2'd2; req_phase = 2'd3;
      tick();
      send_in(FS);
      exp_frame = exp_frame + 16'd1;
      checks++;
      if (state !== 2'd1 || frame_count !== exp_frame || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL drain_refs_state: got state=%0d frame=%0d sync=%0d expected 1 %0d 0",
                  state, frame_count, sync_err, exp_frame);
      end
      checks++;
      if (enable_bilinear !== 1'b1 || enable_ed !== 1'b0 || phase !== 2'd1 || switch_count !== exp_switch) begin
         errors++;
         $display("FAIL drain_refs_cfg: got bl=%0d ed=%0d phase=%0d switch=%0d expected 1 0 1 %0d",
                  enable_bilinear, enable_ed, phase, switch_count, exp_switch);
      end
      send_in(FE);
      dvo_mux = 1'b1; dtypeo_mux = FE;
      tick();
      dvo_mux = 1'b0; dtypeo_mux = 5'h00;
      tick();
      exp_switch = exp_switch + 8'd1;
      checks++;
      if (enable_ed !== 1'b1 || phase !== 2'd3 || switch_count !== exp_switch) begin
         errors++;
         $display("FAIL drain_refs_apply: got ed=%0d phase=%0d switch=%0d expected 1 3 %0d",
                  enable_ed, phase, switch_count, exp_switch);
      end
      $display("test_drain_refs: state=%0d phase=%0d switch=%0d", state, phase, switch_count);
   endtask

   task automatic test_mode3_alias();
      req_mode = 2'd3;
      tick();
      exp_switch = exp_switch + 8'd1;
      checks++;
      if (enable_bilinear !== 1'b1 || enable_ed !== 1'b0 || switch_count !== exp_switch) begin
         errors++;
         $display("FAIL mode3: got bl=%0d ed=%0d switch=%0d expected 1 0 %0d",
                  enable_bilinear, enable_ed, switch_count, exp_switch);
      end
      req_mode = 2'd1;
      tick(); tick();
      checks++;
      if (enable_bilinear !== 1'b1 || switch_count !== exp_switch) begin
         errors++;
         $display("FAIL mode3_alias: got bl=%0d switch=%0d expected 1 %0d",
                  enable_bilinear, switch_count, exp_switch);
      end
      $display("test_mode3_alias: bl=%0d switch=%0d", enable_bilinear, switch_count);
   endtask

   task automatic test_async_reset();
      send_in(FS);
      #2;
      resetb = 1'b0;
      #1;
      checks++;
      if (state !== 2'd0 || enable_bilinear !== 1'b0 || frame_count !== 16'd0 || switch_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got state=%0d bl=%0d frame=%0d switch=%0d expected 0 0 0 0",
                  state, enable_bilinear, frame_count, switch_count);
      end
      tick();
      resetb = 1'b1;
      tick();
      $display("test_async_reset: state=%0d frame=%0d", state, frame_count);
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_idle_follow();
      test_frame_drain();
      test_bypass_drain();
      test_timeout();
      test_sync_err();
      test_drain_refs();
      test_mode3_alias();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interp_mode_ctrl.md
Name: interp_mode_ctrl

Overview:
- Frame-synchronous controller for the demosaic stage: owns enable_bilinear, enable_ed and phase, which drive the bilinear and edge-directed interpolators and the output mux select.
- Takes unsynchronised requests from the DI register terminal and applies them only between frames, so a mode or phase change never splits a frame.
- Watches the raw input stream and the muxed interpolator output, and holds configuration frozen until the in-flight frame has fully drained.

Parameters:
- DTYPE_WIDTH, 5, width of dtype fields.
- FRAME_START, 5'h01, dtype code marking frame start.
- FRAME_END, 5'h02, dtype code marking frame end.
- TIMEOUT_CYCLES, 4096, maximum drain wait in clocks before forced release.
- CNT_WIDTH, 13, width of drain timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- img_clk  in  1  pixel clock; the only clock.
- resetb  in  1  asynchronous active-low reset.
- req_mode  in  2  requested mode: 0 bypass, 1 bilinear, 2 edge-directed, 3 treated as 1.
- req_phase  in  2  requested Bayer phase.
- err_clr  in  1  single-cycle pulse; clears sticky errors.
- dvi  in  1  input stream valid, upstream of the interpolators.
- dtypei  in  DTYPE_WIDTH  input stream dtype.
- dvo_mux  in  1  muxed interpolator output valid.
- dtypeo_mux  in  DTYPE_WIDTH  muxed interpolator output dtype.
- enable_bilinear  out  1  bilinear interpolator enable.
- enable_ed  out  1  edge-directed enable; also the output mux select.
- phase  out  2  applied Bayer phase.
- busy  out  1  high whenever state is not IDLE.
- state  out  2  0 IDLE, 1 RUN, 2 DRAIN.
- timeout_err  out  1  sticky: drain timed out.
- sync_err  out  1  sticky: FRAME_START seen while in RUN.
- frame_count  out  16  number of accepted frame starts; wraps.
- switch_count  out  8  number of applied configuration changes; wraps.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0; the applied configuration register holds mode 0 (bypass), phase 0.
- Strobes: in_fs = dvi & dtypei==FRAME_START; in_fe = dvi & dtypei==FRAME_END; out_fe = dvo_mux & dtypeo_mux==FRAME_END.
- IDLE:
  - Each clock, register req_mode and req_phase into the applied configuration, so outputs follow requests with 1-cycle latency.
  - switch_count += 1 on any clock where the newly registered {mode, phase} differs from the current value.
  - On in_fs: go to RUN, do not update the configuration that cycle (the interpolator samples the already-registered value with the frame-start word), frame_count += 1.
- RUN:
  - Configuration frozen; request changes are ignored until IDLE.
  - On in_fe: go to DRAIN and clear the timeout counter.
  - On in_fs: set sync_err, frame_count += 1, stay in RUN.
  - If in_fe and in_fs occur in the same cycle, in_fe takes priority.
- DRAIN:
  - Configuration frozen; timeout counter increments each clock.
  - out_fe: go to IDLE.
  - Applied mode is bypass: go to IDLE on the first DRAIN cycle, since there is no pipeline to drain.
  - Counter reaches TIMEOUT_CYCLES-1: set timeout_err and go to IDLE.
  - in_fs (next frame arrives before drain completes): go to RUN with configuration still frozen, frame_count += 1; no error.
  - Priority when events coincide: in_fs > out_fe > timeout.
- Mode decode (registered): bypass gives both enables 0; bilinear gives enable_bilinear=1, enable_ed=0; edge-directed gives enable_ed=1, enable_bilinear=0. Both enables are never high together.
- err_clr clears both sticky bits. If err_clr coincides with a new error event, the error wins (the bit stays 1).
- Counters wrap silently.
- Asynchronous reset mid-frame returns to IDLE/bypass immediately; the partial frame is not tracked.

Test Plan:
- Reset, req_mode=2, req_phase=1, idle 2 clocks -> enable_ed=1, enable_bilinear=0, phase=1, switch_count=1, state=0.
- Frame start with req_mode=2 -> state=1, frame_count=1. Change req_mode to 1 mid-frame -> enable_ed stays 1. in_fe, then out_fe 20 clocks later -> state=2 for 20 clocks, then 0; enable_bilinear=1 one clock after return to IDLE; switch_count=2.
- Mode 0: frame start, then frame end -> DRAIN lasts exactly 1 clock, then IDLE; timeout_err=0.
- Mode 1 with out_fe withheld -> after 4096 DRAIN clocks state=0 and timeout_err=1. err_clr pulse -> timeout_err=0.
- Two FRAME_START words with no FRAME_END between them -> sync_err=1, frame_count=2, state=1. Simultaneous in_fs and in_fe in RUN -> state=2.
- In DRAIN, in_fs before out_fe -> state=1 and configuration unchanged even though req_mode was altered during DRAIN.
